// File: rtl/nibble_acc_reg.sv
// Accumulator register A of the Nibbler datapath: load-enabled nibble register.
// Optional zero flag output is enabled by defining NIBBLE_ACC_ZERO_FLAG_EN.
module nibble_acc_reg #(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] dataIn,
  input  logic             reset,
  input  logic             clk,
  input  logic             enable,
  output logic [WIDTH-1:0] dataOut
`ifdef NIBBLE_ACC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  // Reset outranks enable; otherwise the register holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= RESET_VALUE;
    end else if (enable) begin
      dataOut <= dataIn;
    end
  end

`ifdef NIBBLE_ACC_ZERO_FLAG_EN
  // Decoded from the register so it tracks dataOut, including X.
  assign zero = (dataOut == '0);
`endif

endmodule

// File: tb/tb_nibble_acc_reg.sv
// Self-checking bench for nibble_acc_reg: directed plan plus random traffic
// against a behavioural model (covers zero flag when NIBBLE_ACC_ZERO_FLAG_EN).
module tb_nibble_acc_reg;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] dataIn;
  logic [W-1:0] dataOut;
`ifdef NIBBLE_ACC_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks;
  int errors;
  logic [W-1:0] model;

  nibble_acc_reg #(
    .WIDTH(W),
    .RESET_VALUE('0)
  ) dut (
    .dataIn (dataIn),
    .reset  (reset),
    .clk    (clk),
    .enable (enable),
    .dataOut(dataOut)
`ifdef NIBBLE_ACC_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, advance the model, compare after it.
  task automatic cycle(input logic r,
                       input logic e,
                       input logic [W-1:0] d,
                       input string tag);
    reset  = r;
    enable = e;
    dataIn = d;
    @(posedge clk);
    if (r)      model = '0;
    else if (e) model = d;
    #1;
    check(tag, {4'b0, dataOut}, {4'b0, model});
`ifdef NIBBLE_ACC_ZERO_FLAG_EN
    check({tag, "_zero"}, {7'b0, zero}, {7'b0, model == 0});
`endif
  endtask

  // Wiggle dataIn/enable between edges, then confirm nothing moved.
  task automatic glitch(input string tag);
    for (int k = 0; k < 3; k++) begin
      dataIn = W'($urandom);
      enable = ~enable;
      #1;
    end
    enable = 1'b0;
    #1;
    check(tag, {4'b0, dataOut}, {4'b0, model});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = '0;
    reset  = 1'b0;
    enable = 1'b0;
    dataIn = '0;
    @(negedge clk);

    cycle(1, 0, 4'b0001, "reset1");
    cycle(1, 0, 4'b0011, "reset2");
    cycle(0, 0, 4'b1100, "no_enable");
    cycle(0, 1, 4'b1100, "load_1100");
    cycle(0, 1, 4'b0110, "load_0110");
    cycle(0, 1, 4'b1001, "load_1001");
    cycle(1, 1, 4'b0000, "reset_prio");
    cycle(0, 1, 4'b1010, "load_1010");
    cycle(0, 0, 4'b0101, "hold_a");
    cycle(0, 0, 4'b1111, "hold_b");
    cycle(0, 0, 4'b0101, "hold_c");
    glitch("between_edges");
    cycle(0, 1, 4'b0001, "load_0001");
    cycle(0, 1, 4'b0000, "load_0000");
    cycle(1, 0, 4'b1111, "reset_again");
    cycle(0, 1, 4'b1111, "load_1111");
    cycle(1, 1, 4'b1111, "reset_vs_ones");

    for (int i = 0; i < 300; i++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 19) == 0);
      e = $urandom_range(0, 1) == 1;
      cycle(r, e, W'($urandom), "random");
      if ($urandom_range(0, 9) == 0) glitch("random_glitch");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
